prime_sieve_ctrl: RTL and testbench
===================================

Name: prime_sieve_ctrl

Overview:
Memory-mapped controller that runs prime generation as a multi-cycle Sieve of Eratosthenes instead of a single-cycle loop. It sequences a composite-flag bitmap and writes the results into a prime table. It sits on the same chip-select/read/write slave bus as the adder/multiplier/prime function blocks. Software writes a limit, polls status or oDone, then reads the count and the primes by index.

Parameters:
N_W, 10, width of limit/candidate values; MAX_N = 2**N_W - 1
TABLE_DEPTH, 256, number of prime table entries
IDX_W, 8, index width, $clog2(TABLE_DEPTH)

Ports:
iClk  input  1  clock
iReset_n  input  1  reset, synchronous, active-low
iChip_select_n  input  1  bus select, active-low
iWrite_n  input  1  write strobe, active-low
iRead_n  input  1  read strobe, active-low
iAddress  input  3  register select
iData  input  32  write data
oData  output  32  registered read data
oBusy  output  1  sieve/collect in progress
oDone  output  1  sticky run-complete flag

Behaviour:
- Clock and reset: single clock iClk. iReset_n is synchronous and active-low.
- Reset values: state IDLE; oData=0, oBusy=0, oDone=0; count=0, index=0, overflow=0; bitmap cleared. Table contents are don't-care.
- Bus decode: a write is cs&wr, a read is cs&rd. If both are asserted, the write wins and oData holds.
- Read latency: oData is updated at t+1 for a read strobe at t. It holds between reads. Unmapped addresses read 0.
- Register map:
  - addr0 W: limit = iData[N_W-1:0] and start. Ignored while oBusy=1.
  - addr0 R: {29'b0, overflow, oDone, oBusy}.
  - addr1 W: index = iData[IDX_W-1:0].
  - addr1 R: table[index] if index < count, else 0.
  - addr2 R: count, zero-extended.
  - addr3 W: abort, data ignored.
- Start (IDLE, addr0 write):
  - Clear bitmap in the same cycle; count=0, overflow=0, oDone=0.
  - If limit < 2, go straight to DONE. Otherwise p=2 and go to SCAN.
- SCAN, one cycle per p:
  - If p*p > limit (2*N_W-bit product), set c=2 and go to COLLECT.
  - Else if bitmap[p]=1, p=p+1.
  - Else m=p*p and go to MARK.
- MARK, one mark per cycle:
  - bitmap[m]=1; m=m+p, computed in N_W+1 bits so it never wraps.
  - If m+p > limit, p=p+1 and go to SCAN.
- COLLECT, one candidate per cycle:
  - If bitmap[c]=0 and count < TABLE_DEPTH: table[count]=c, count=count+1.
  - If bitmap[c]=0 and count = TABLE_DEPTH: overflow=1 and the prime is dropped.
  - When c = limit, go to DONE; otherwise c=c+1.
- DONE (one cycle): oDone=1 (sticky until next start), then go to IDLE.
- oBusy: 1 in SCAN/MARK/COLLECT, 0 in IDLE/DONE. Goes high the cycle after the start write.
- Abort (addr3) in any busy state: next state IDLE, oBusy=0, oDone=0. count and table keep their partial results. Abort in IDLE is a no-op.
- Reads while busy return live values (status, current count, written entries).
- Synchronous reset mid-run: same as reset values; the run is lost.
- Limit = MAX_N: all indices stay within bitmap range 0..MAX_N.

Decomposition:
- Package prime_sieve_pkg contains:
  - address constants ADDR_CTRL=0, ADDR_INDEX=1, ADDR_COUNT=2, ADDR_ABORT=3;
  - status bit positions BUSY=0, DONE=1, OVF=2;
  - state enum {IDLE, SCAN, MARK, COLLECT, DONE}.
- Sub-module prime_table: TABLE_DEPTH x N_W register array with one synchronous write port and one combinational read port, no reset. The controller holds the FSM, bitmap, counters and bus decode.

Test Plan:
- Reset, then read addr0/addr2 -> oData=0 both; oBusy=0, oDone=0.
- Write addr0=10, poll until oDone -> count=4; indices 0..3 read 2,3,5,7; index 4 reads 0; overflow=0.
- Write addr0=1, then addr0=2 -> first run: oDone with count=0; second run: count=1, table[0]=2.
- Write addr0=1023 -> count=172, table[171]=1021, table[0]=2; a second addr0 write while busy is ignored, giving the same result.
- TABLE_DEPTH=4, write addr0=20 -> count=4, entries 2,3,5,7, status overflow=1.
- Start limit 1023, abort after 20 cycles -> oBusy=0 next cycle, oDone=0; read and write asserted together on addr0 -> write only, oData unchanged.

Source files
------------

// File: rtl/prime_sieve_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prime_sieve_pkg
// Purpose  : Shared constants and FSM state type for the prime sieve
//            controller and its prime table.
// Revision : 1.0 - initial release
// ============================================================================
package prime_sieve_pkg;

   // Register addresses on the slave bus
   localparam logic [2:0] ADDR_CTRL  = 3'd0;
   localparam logic [2:0] ADDR_INDEX = 3'd1;
   localparam logic [2:0] ADDR_COUNT = 3'd2;
   localparam logic [2:0] ADDR_ABORT = 3'd3;

   // Bit positions inside the status word read from ADDR_CTRL
   localparam int BIT_BUSY = 0;
   localparam int BIT_DONE = 1;
   localparam int BIT_OVF  = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SCAN    = 3'd1,
      MARK    = 3'd2,
      COLLECT = 3'd3,
      DONE    = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/prime_table.sv
`default_nettype none
// ============================================================================
// Module   : prime_table
// Purpose  : Storage for discovered primes. One synchronous write port, one
//            combinational read port, contents undefined after reset.
// Revision : 1.0 - initial release
// ============================================================================
module prime_table #(
   parameter int N_W   = 10,
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [N_W-1:0]   wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [N_W-1:0]   rdata_o
);

   logic [N_W-1:0] mem_q [DEPTH];

   // Store one prime per write strobe
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/prime_sieve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prime_sieve_ctrl
// Purpose  : Bus-mapped multi-cycle Sieve of Eratosthenes. Marks composites
//            in a bitmap, then collects the unmarked candidates into a table
//            that software reads back by index.
// Revision : 1.0 - initial release
// ============================================================================
module prime_sieve_ctrl
   import prime_sieve_pkg::*;
#(
   parameter int N_W         = 10,
   parameter int TABLE_DEPTH = 256,
   parameter int IDX_W       = 8
) (
   input  logic        iClk,
   input  logic        iReset_n,
   input  logic        iChip_select_n,
   input  logic        iWrite_n,
   input  logic        iRead_n,
   input  logic [2:0]  iAddress,
   input  logic [31:0] iData,
   output logic [31:0] oData,
   output logic        oBusy,
   output logic        oDone
);

   localparam int MAX_N = 2**N_W - 1;
   // count must be able to hold TABLE_DEPTH itself, hence one extra bit
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TABLE_DEPTH);

   state_e             state_q, state_d;
   logic [N_W-1:0]     limit_q, limit_d;
   logic [N_W-1:0]     p_q,     p_d;
   logic [N_W:0]       m_q,     m_d;
   logic [N_W-1:0]     c_q,     c_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [IDX_W-1:0]   index_q, index_d;
   logic               ovf_q,   ovf_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;
   logic [31:0]        data_q,  data_d;
   logic [MAX_N:0]     bitmap_q, bitmap_d;

   logic               w_wr, w_rd, w_start, w_abort;
   logic [2*N_W-1:0]   w_pp;
   logic [N_W:0]       w_m_next;
   logic               w_tbl_we;
   logic [N_W-1:0]     w_tbl_rd;
   logic [31:0]        w_rd_mux;
   logic               w_unused;

   // Write beats read when both strobes are asserted together
   assign w_wr    = ~iChip_select_n & ~iWrite_n;
   assign w_rd    = ~iChip_select_n & ~iRead_n & ~w_wr;
   assign w_start = w_wr && (iAddress == ADDR_CTRL) && !busy_q;
   assign w_abort = w_wr && (iAddress == ADDR_ABORT) && busy_q;

   // Full-width square so the termination test cannot be fooled by overflow
   assign w_pp     = {{N_W{1'b0}}, p_q} * {{N_W{1'b0}}, p_q};
   // One extra bit keeps m+p from wrapping back into the bitmap at MAX_N
   assign w_m_next = m_q + {1'b0, p_q};

   assign w_tbl_we = (state_q == COLLECT) && !bitmap_q[c_q] && (count_q < DEPTH_C);

   // Only the low N_W bits of write data are meaningful
   assign w_unused = &{1'b0, iData[31:N_W]};

   prime_table #(
      .N_W   (N_W),
      .DEPTH (TABLE_DEPTH),
      .IDX_W (IDX_W)
   ) u_table (
      .clk_i   (iClk),
      .we_i    (w_tbl_we),
      .waddr_i (count_q[IDX_W-1:0]),
      .wdata_i (c_q),
      .raddr_i (index_q),
      .rdata_o (w_tbl_rd)
   );

   // Read-data decode; entries at or beyond count read as zero
   always_comb begin
      w_rd_mux = '0;
      case (iAddress)
         ADDR_CTRL:  w_rd_mux = {29'b0, ovf_q, done_q, busy_q};
         ADDR_INDEX: if ({1'b0, index_q} < count_q) w_rd_mux = {{(32-N_W){1'b0}}, w_tbl_rd};
         ADDR_COUNT: w_rd_mux = {{(32-CNT_W){1'b0}}, count_q};
         default:    w_rd_mux = '0;
      endcase
   end

   // Next-state logic for the sieve FSM, counters, bitmap and bus registers
   always_comb begin
      state_d  = state_q;
      limit_d  = limit_q;
      p_d      = p_q;
      m_d      = m_q;
      c_d      = c_q;
      count_d  = count_q;
      index_d  = index_q;
      ovf_d    = ovf_q;
      done_d   = done_q;
      data_d   = data_q;
      bitmap_d = bitmap_q;

      if (w_wr && (iAddress == ADDR_INDEX)) index_d = iData[IDX_W-1:0];
      if (w_rd) data_d = w_rd_mux;

      case (state_q)
         IDLE: ;
         DONE: state_d = IDLE;
         SCAN: begin
            if (w_pp > {{N_W{1'b0}}, limit_q}) begin
               c_d     = N_W'(2);
               state_d = COLLECT;
            end else if (bitmap_q[p_q]) begin
               p_d = p_q + N_W'(1);
            end else begin
               m_d     = w_pp[N_W:0];
               state_d = MARK;
            end
         end
         MARK: begin
            bitmap_d[m_q[N_W-1:0]] = 1'b1;
            m_d = w_m_next;
            if (w_m_next > {1'b0, limit_q}) begin
               p_d     = p_q + N_W'(1);
               state_d = SCAN;
            end
         end
         COLLECT: begin
            if (!bitmap_q[c_q]) begin
               if (count_q < DEPTH_C) count_d = count_q + CNT_W'(1);
               else                   ovf_d   = 1'b1;
            end
            if (c_q == limit_q) state_d = DONE;
            else                c_d     = c_q + N_W'(1);
         end
         default: state_d = IDLE;
      endcase

      if (w_start) begin
         limit_d  = iData[N_W-1:0];
         bitmap_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         done_d   = 1'b0;
         p_d      = N_W'(2);
         state_d  = (iData[N_W-1:0] < N_W'(2)) ? DONE : SCAN;
      end

      if (w_abort) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end

      if (state_d == DONE) done_d = 1'b1;
      busy_d = (state_d == SCAN) || (state_d == MARK) || (state_d == COLLECT);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state_q  <= IDLE;
         limit_q  <= '0;
         p_q      <= '0;
         m_q      <= '0;
         c_q      <= '0;
         count_q  <= '0;
         index_q  <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         data_q   <= '0;
         bitmap_q <= '0;
      end else begin
         state_q  <= state_d;
         limit_q  <= limit_d;
         p_q      <= p_d;
         m_q      <= m_d;
         c_q      <= c_d;
         count_q  <= count_d;
         index_q  <= index_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         data_q   <= data_d;
         bitmap_q <= bitmap_d;
      end
   end

   assign oData = data_q;
   assign oBusy = busy_q;
   assign oDone = done_q;

endmodule
`default_nettype wire

// File: tb/tb_prime_sieve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prime_sieve_ctrl
// Purpose  : Self-checking bench for prime_sieve_ctrl. Instance 0 uses the
//            default table depth, instance 1 a 4-entry table for overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prime_sieve_ctrl;
   import prime_sieve_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs0_n, cs1_n, wr_n, rd_n;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata0, rdata1;
   logic        busy0, busy1, done0, done1;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   int          model_primes[$];

   always #5 clk = ~clk;

   prime_sieve_ctrl u_dut0 (
      .iClk(clk), .iReset_n(rst_n), .iChip_select_n(cs0_n), .iWrite_n(wr_n),
      .iRead_n(rd_n), .iAddress(addr), .iData(wdata), .oData(rdata0),
      .oBusy(busy0), .oDone(done0)
   );

   prime_sieve_ctrl #(.N_W(10), .TABLE_DEPTH(4), .IDX_W(2)) u_dut1 (
      .iClk(clk), .iReset_n(rst_n), .iChip_select_n(cs1_n), .iWrite_n(wr_n),
      .iRead_n(rd_n), .iAddress(addr), .iData(wdata), .oData(rdata1),
      .oBusy(busy1), .oDone(done1)
   );

   // Reference: primes up to limit by trial division
   function automatic void model(input int limit);
      model_primes.delete();
      for (int n = 2; n <= limit; n++) begin
         bit is_p = 1'b1;
         for (int d = 2; d * d <= n; d++) if (n % d == 0) is_p = 1'b0;
         if (is_p) model_primes.push_back(n);
      end
   endfunction

   task automatic bus_idle();
      cs0_n = 1'b1; cs1_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
      addr = '0; wdata = '0;
   endtask

   task automatic bus_write(input int s, input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      cs0_n = (s != 0); cs1_n = (s != 1);
      wr_n = 1'b0; rd_n = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_read(input int s, input logic [2:0] a, output logic [31:0] v);
      @(negedge clk);
      cs0_n = (s != 0); cs1_n = (s != 1);
      wr_n = 1'b1; rd_n = 1'b0; addr = a;
      @(negedge clk);
      bus_idle();
      v = (s == 0) ? rdata0 : rdata1;
   endtask

   task automatic wait_done(input int s, input int max_cycles, output bit ok);
      for (int i = 0; i < max_cycles; i++) begin
         if (((s == 0) ? done0 : done1) === 1'b1) break;
         @(negedge clk);
      end
      ok = ((s == 0) ? done0 : done1) === 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] v, e;
      bus_idle();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      vectors++;
      if ({busy0, done0, busy1, done1} !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_flags got=%b exp=0000", {busy0, done0, busy1, done1});
      end
      for (int s = 0; s < 2; s++) begin
         exp_q.push_back(32'h0);
         bus_read(s, ADDR_CTRL, v);
         e = exp_q.pop_front(); vectors++;
         if (v !== e) begin miscompares++; $display("FAIL reset_status dut%0d got=%h exp=%h", s, v, e); end
         exp_q.push_back(32'h0);
         bus_read(s, ADDR_COUNT, v);
         e = exp_q.pop_front(); vectors++;
         if (v !== e) begin miscompares++; $display("FAIL reset_count dut%0d got=%h exp=%h", s, v, e); end
      end
   endtask

   task automatic test_limit10();
      logic [31:0] v, e;
      bit ok;
      model(10);
      bus_write(0, ADDR_CTRL, 32'd10);
      vectors++;
      if (busy0 !== 1'b1) begin miscompares++; $display("FAIL l10_busy got=%b exp=1", busy0); end
      wait_done(0, 2000, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL l10_done_timeout got=0 exp=1"); end
      exp_q.push_back(32'(model_primes.size()));
      bus_read(0, ADDR_COUNT, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL l10_count got=%0d exp=%0d", v, e); end
      for (int i = 0; i <= model_primes.size(); i++) begin
         bus_write(0, ADDR_INDEX, 32'(i));
         exp_q.push_back((i < model_primes.size()) ? 32'(model_primes[i]) : 32'h0);
         bus_read(0, ADDR_INDEX, v);
         e = exp_q.pop_front(); vectors++;
         if (v !== e) begin miscompares++; $display("FAIL l10_entry[%0d] got=%0d exp=%0d", i, v, e); end
      end
      exp_q.push_back(32'h2);
      bus_read(0, ADDR_CTRL, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL l10_status got=%h exp=%h", v, e); end
   endtask

   task automatic test_small_limits();
      logic [31:0] v, e;
      bit ok;
      bus_write(0, ADDR_CTRL, 32'd1);
      wait_done(0, 100, ok);
      vectors++;
      if (!ok || busy0 !== 1'b0) begin miscompares++; $display("FAIL lim1_done got=%b/%b exp=1/0", ok, busy0); end
      exp_q.push_back(32'h0);
      bus_read(0, ADDR_COUNT, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL lim1_count got=%0d exp=%0d", v, e); end
      bus_write(0, ADDR_CTRL, 32'd2);
      vectors++;
      if (done0 !== 1'b0) begin miscompares++; $display("FAIL lim2_done_clear got=%b exp=0", done0); end
      wait_done(0, 100, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL lim2_done_timeout got=0 exp=1"); end
      exp_q.push_back(32'd1);
      bus_read(0, ADDR_COUNT, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL lim2_count got=%0d exp=%0d", v, e); end
      bus_write(0, ADDR_INDEX, 32'd0);
      exp_q.push_back(32'd2);
      bus_read(0, ADDR_INDEX, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL lim2_entry0 got=%0d exp=%0d", v, e); end
   endtask

   task automatic test_full_range();
      logic [31:0] v, e;
      bit ok;
      model(1023);
      bus_write(0, ADDR_CTRL, 32'd1023);
      bus_write(0, ADDR_CTRL, 32'd5);
      vectors++;
      if (busy0 !== 1'b1) begin miscompares++; $display("FAIL full_busy got=%b exp=1", busy0); end
      wait_done(0, 20000, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL full_done_timeout got=0 exp=1"); end
      exp_q.push_back(32'(model_primes.size()));
      bus_read(0, ADDR_COUNT, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL full_count got=%0d exp=%0d", v, e); end
      for (int i = 0; i <= model_primes.size(); i++) begin
         bus_write(0, ADDR_INDEX, 32'(i));
         exp_q.push_back((i < model_primes.size()) ? 32'(model_primes[i]) : 32'h0);
         bus_read(0, ADDR_INDEX, v);
         e = exp_q.pop_front(); vectors++;
         if (v !== e) begin miscompares++; $display("FAIL full_entry[%0d] got=%0d exp=%0d", i, v, e); end
      end
      exp_q.push_back(32'h2);
      bus_read(0, ADDR_CTRL, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL full_status got=%h exp=%h", v, e); end
   endtask

   task automatic test_overflow();
      logic [31:0] v, e;
      bit ok;
      model(20);
      bus_write(1, ADDR_CTRL, 32'd20);
      wait_done(1, 2000, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL ovf_done_timeout got=0 exp=1"); end
      exp_q.push_back(32'd4);
      bus_read(1, ADDR_COUNT, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL ovf_count got=%0d exp=%0d", v, e); end
      for (int i = 0; i < 4; i++) begin
         bus_write(1, ADDR_INDEX, 32'(i));
         exp_q.push_back(32'(model_primes[i]));
         bus_read(1, ADDR_INDEX, v);
         e = exp_q.pop_front(); vectors++;
         if (v !== e) begin miscompares++; $display("FAIL ovf_entry[%0d] got=%0d exp=%0d", i, v, e); end
      end
      exp_q.push_back(32'h6);
      bus_read(1, ADDR_CTRL, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL ovf_status got=%h exp=%h", v, e); end
   endtask

   task automatic test_abort();
      logic [31:0] v, e;
      bus_write(0, ADDR_CTRL, 32'd1023);
      repeat (20) @(negedge clk);
      bus_write(0, ADDR_ABORT, 32'hFFFF_FFFF);
      vectors++;
      if ({busy0, done0} !== 2'b00) begin
         miscompares++;
         $display("FAIL abort_flags got=%b exp=00", {busy0, done0});
      end
      exp_q.push_back(32'h0);
      bus_read(0, ADDR_COUNT, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL abort_count got=%0d exp=%0d", v, e); end
      exp_q.push_back(32'h0);
      bus_read(0, ADDR_CTRL, v);
      e = exp_q.pop_front(); vectors++;
      if (v !== e) begin miscompares++; $display("FAIL abort_status got=%h exp=%h", v, e); end
   endtask

   task automatic test_rd_wr_collision();
      logic [31:0] v, e;
      bit ok;
      bus_write(0, ADDR_CTRL, 32'd2);
      wait_done(0, 100, ok);
      exp_q.push_back(32'd1);
      bus_read(0, ADDR_COUNT, v);
      e = exp_q.pop_front(); vectors++;
      if (!ok || v !== e) begin miscompares++; $display("FAIL coll_setup got=%0d/%b exp=%0d/1", v, ok, e); end
      // Read and write together: the write starts a run, oData holds
      @(negedge clk);
      cs0_n = 1'b0; cs1_n = 1'b1; wr_n = 1'b0; rd_n = 1'b0; addr = ADDR_CTRL; wdata = 32'd3;
      exp_q.push_back(32'd1);
      @(negedge clk);
      bus_idle();
      e = exp_q.pop_front(); vectors++;
      if (rdata0 !== e) begin miscompares++; $display("FAIL coll_hold got=%h exp=%h", rdata0, e); end
      vectors++;
      if (busy0 !== 1'b1) begin miscompares++; $display("FAIL coll_write_busy got=%b exp=1", busy0); end
      wait_done(0, 200, ok);
      exp_q.push_back(32'd2);
      bus_read(0, ADDR_COUNT, v);
      e = exp_q.pop_front(); vectors++;
      if (!ok || v !== e) begin miscompares++; $display("FAIL coll_count got=%0d/%b exp=%0d/1", v, ok, e); end
   endtask

   initial begin
      test_reset();
      test_limit10();
      test_small_limits();
      test_full_range();
      test_overflow();
      test_abort();
      test_rd_wr_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
